fc_mem_arbiter: RTL
===================

FC_MEM_ARBITER -- requirements
Module: fc_mem_arbiter

Interface
REQ-001 Parameter ADDR_WID, default 16, memory address width.
REQ-002 Parameter DATA_WID, default 16, memory data width.
REQ-003 Parameter MEM_LAT, default 1, memory read latency in cycles (range 1..4).
REQ-004 Parameter STARVE_LIMIT, default 8, loader wait cycles before forced loader priority (range 1..255).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 cmp_req  in  1  compute engine read request.
REQ-008 cmp_addr  in  ADDR_WID  compute read address.
REQ-009 cmp_gnt  out  1  compute request accepted this cycle.
REQ-010 cmp_rdata  out  DATA_WID  read data (pass-through of mem_rdata).
REQ-011 cmp_rvalid  out  1  cmp_rdata valid.
REQ-012 ld_req  in  1  weight/bias loader write request.
REQ-013 ld_addr  in  ADDR_WID  loader write address.
REQ-014 ld_wdata  in  DATA_WID  loader write data.
REQ-015 ld_last  in  1  final word of loader burst.
REQ-016 ld_gnt  out  1  loader write accepted this cycle.
REQ-017 mem_en, mem_we  out  1 each  memory enable / write enable.
REQ-018 mem_addr  out  ADDR_WID; mem_wdata  out  DATA_WID; mem_rdata  in  DATA_WID.
REQ-019 ld_locked  out  1  loader burst in progress.

Function
REQ-020 The block SHALL grant at most one requester per cycle; grants are combinational from current requests and registered state.
REQ-021 Default priority: compute wins when both request and no lock or starvation override is active.
REQ-022 Starvation counter (8 bits): increments each cycle ld_req=1 and ld_gnt=0; clears on ld_gnt=1 or ld_req=0; saturates at STARVE_LIMIT.
REQ-023 Counter at STARVE_LIMIT: loader wins the next contested cycle.
REQ-024 Lock: set on a cycle with ld_gnt=1 and ld_last=0; cleared on a cycle with ld_gnt=1 and ld_last=1; ld_locked = lock register.
REQ-025 While locked, cmp_gnt SHALL be 0 regardless of cmp_req; ld_gnt = ld_req.
REQ-026 While locked with ld_req=0, no grant; lock held (memory idle, mem_en=0).
REQ-027 Single-word burst (ld_last=1 on first grant) SHALL not set the lock.
REQ-028 Compute grant: mem_en=1, mem_we=0, mem_addr=cmp_addr.
REQ-029 Loader grant: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_wdata.
REQ-030 No grant: mem_en=0, mem_we=0, mem_addr and mem_wdata=0.
REQ-031 cmp_rvalid SHALL assert exactly MEM_LAT cycles after each cmp_gnt, one pulse per grant, via MEM_LAT-deep shift register; back-to-back grants give back-to-back rvalid.
REQ-032 cmp_rdata = mem_rdata combinationally; content is meaningful only when cmp_rvalid=1.
REQ-033 Read and write to the same address in consecutive cycles SHALL be issued in grant order; no reordering or forwarding.

Reset
REQ-034 During rst=1: all grants, mem_en, mem_we, cmp_rvalid, ld_locked = 0; mem_addr, mem_wdata = 0.
REQ-035 On rst: lock cleared, starvation counter = 0, rvalid shift register cleared; reads in flight are dropped (no rvalid after reset).
REQ-036 Reset mid-burst: lock released; the first cycle after reset is arbitrated per REQ-021.

Verification
REQ-037 cmp_req=1 only, addresses 0..3 on 4 cycles, MEM_LAT=1 -> cmp_gnt=1 all 4 cycles, cmp_rvalid=1 on cycles 2..5, mem_we=0 throughout.
REQ-038 cmp_req and ld_req held 1, STARVE_LIMIT=8, ld_last=1 -> cmp_gnt for 8 cycles, ld_gnt on cycle 9, cmp_gnt resumes on cycle 10.
REQ-039 Loader burst of 4 words (ld_last on 4th) while cmp_req=1 -> ld_locked=1 from cycle after first ld_gnt through 4th ld_gnt; cmp_gnt=0 for that span; cmp_gnt=1 on following cycle.
REQ-040 Locked burst with ld_req dropped 3 cycles mid-burst, cmp_req=1 -> mem_en=0 and cmp_gnt=0 for those 3 cycles; burst completes on ld_req return.
REQ-041 rst=1 asserted for 1 cycle after cmp_gnt at MEM_LAT=2 and mid-burst -> no cmp_rvalid afterward, ld_locked=0, next contested cycle grants compute.

Source files
------------

// File: rtl/fc_mem_arbiter.sv
// Single-port memory arbiter between a compute read engine and a weight/bias loader.
// Compute has default priority; a starvation counter and a burst lock give the loader its turn.
module fc_mem_arbiter #(
    parameter int ADDR_WID     = 16,
    parameter int DATA_WID     = 16,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmp_req,
    input  logic [ADDR_WID-1:0] cmp_addr,
    output logic                cmp_gnt,
    output logic [DATA_WID-1:0] cmp_rdata,
    output logic                cmp_rvalid,
    input  logic                ld_req,
    input  logic [ADDR_WID-1:0] ld_addr,
    input  logic [DATA_WID-1:0] ld_wdata,
    input  logic                ld_last,
    output logic                ld_gnt,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_WID-1:0] mem_addr,
    output logic [DATA_WID-1:0] mem_wdata,
    input  logic [DATA_WID-1:0] mem_rdata,
    output logic                ld_locked
);

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic               lock_r;
    logic [7:0]         starve_cnt_r;
    logic [MEM_LAT-1:0] rv_sr_r;
    logic               starved_s;

    assign starved_s = (starve_cnt_r >= STARVE_MAX);

    // Grant decision: reset blocks everything, lock hands the port to the loader.
    always_comb begin
        cmp_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (rst) begin
            cmp_gnt = 1'b0;
            ld_gnt  = 1'b0;
        end else if (lock_r) begin
            ld_gnt = ld_req;
        end else if (ld_req && (!cmp_req || starved_s)) begin
            ld_gnt = 1'b1;
        end else if (cmp_req) begin
            cmp_gnt = 1'b1;
        end else begin
            cmp_gnt = 1'b0;
            ld_gnt  = 1'b0;
        end
    end

    // Memory command mux driven by whichever requester holds the grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_WID{1'b0}};
        mem_wdata = {DATA_WID{1'b0}};
        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (cmp_gnt) begin
            mem_en   = 1'b1;
            mem_addr = cmp_addr;
        end else begin
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = {ADDR_WID{1'b0}};
            mem_wdata = {DATA_WID{1'b0}};
        end
    end

    // Burst lock: only a granted non-final word opens it, a granted final word closes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_r <= 1'b0;
        end else if (ld_gnt) begin
            lock_r <= !ld_last;
        end else begin
            lock_r <= lock_r;
        end
    end

    // Starvation counter: counts refused loader cycles, saturating at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= 8'd0;
        end else if (ld_req && !ld_gnt) begin
            if (starve_cnt_r < STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + 8'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= 8'd0;
        end
    end

    // Read-valid pipeline mirrors the fixed memory latency.
    if (MEM_LAT > 1) begin : g_rv_deep
        always_ff @(posedge clk) begin
            if (rst) begin
                rv_sr_r <= {MEM_LAT{1'b0}};
            end else begin
                rv_sr_r <= {rv_sr_r[MEM_LAT-2:0], cmp_gnt};
            end
        end
    end else begin : g_rv_one
        always_ff @(posedge clk) begin
            if (rst) begin
                rv_sr_r <= 1'b0;
            end else begin
                rv_sr_r <= cmp_gnt;
            end
        end
    end

    // Reset masks the registered status so nothing leaks out during the reset cycle.
    assign cmp_rvalid = rv_sr_r[MEM_LAT-1] & ~rst;
    assign ld_locked  = lock_r & ~rst;
    assign cmp_rdata  = mem_rdata;

endmodule
